// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   OPW      - opcode field width
//   opcode_t - operation encodings
//   state_t  - control FSM states (also visible on the dbg_state port)
package alu_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_PASS = 4'd7,
        OP_ADC  = 4'd8,
        OP_SBB  = 4'd9,
        OP_ROL  = 4'd10,
        OP_ROR  = 4'd11,
        OP_ASR  = 4'd12,
        OP_MUL  = 4'd13,
        OP_CMP  = 4'd14,
        OP_RSV  = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - load operands a/b and begin (one-cycle pulse)
//   a, b       - operands, registered on start
//   done       - one-cycle pulse when product is final (WIDTH cycles after start)
//   product    - {hi, lo} product, held until the next start
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [WIDTH:0]   partial;

    // lo starts as the multiplier and fills with product bits from the top
    // as the accumulator shifts right each step.
    assign partial = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign product = {hi, lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand <= a;
                hi    <= '0;
                lo    <= b;
                cnt   <= CW'(WIDTH);
                busy  <= 1'b1;
            end else if (busy) begin
                {hi, lo} <= {partial, lo[WIDTH-1:1]};
                cnt      <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready request and response handshakes.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable while valid is high and ready is low.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - request handshake; a, b, opcode sampled on accept
//   out_valid/out_ready   - response handshake; outputs held while stalled
//   result, result_hi     - result (low half for MUL), high half for MUL
//   carry..negative       - status flags
//   dbg_state             - current FSM state (alu_pkg::state_t encoding)
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             borrow,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic [1:0]       dbg_state
);

    localparam int MSB = WIDTH - 1;

    state_t           state, state_nxt;
    opcode_t          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cst, bst;
    logic             accept, is_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_b, alu_v, alu_z, alu_n, alu_upd;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (MUL_EN != 0) && (opcode_t'(opcode) == OP_MUL);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_MUL:  if (mul_done) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready drops combinationally with rst
    always_comb begin
        in_ready  = (state == ST_IDLE) && !rst;
        out_valid = (state == ST_DONE);
        mul_start = (state == ST_IDLE) && accept && is_mul;
    end

    // Non-MUL datapath, evaluated from the registered request during EXEC.
    // ADC/SBB consume the stored carry/borrow; CMP subtracts without it.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(op_q == OP_ADC ? cst : 1'b0);
        diff    = {1'b0, a_q} - {1'b0, b_q} - (WIDTH + 1)'(op_q == OP_SBB ? bst : 1'b0);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_b   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
                alu_upd = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                alu_res = (op_q == OP_CMP) ? a_q : diff[MSB:0];
                alu_b   = diff[WIDTH];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
                alu_upd = 1'b1;
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_PASS: alu_res = a_q;
            OP_SHL: begin
                alu_res = {a_q[MSB-1:0], 1'b0};
                alu_c   = a_q[MSB];
                alu_upd = 1'b1;
            end
            OP_ROL: begin
                alu_res = {a_q[MSB-1:0], a_q[MSB]};
                alu_c   = a_q[MSB];
                alu_upd = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[MSB:1]};
                alu_c   = a_q[0];
                alu_upd = 1'b1;
            end
            OP_ROR: begin
                alu_res = {a_q[0], a_q[MSB:1]};
                alu_c   = a_q[0];
                alu_upd = 1'b1;
            end
            OP_ASR: begin
                alu_res = {a_q[MSB], a_q[MSB:1]};
                alu_c   = a_q[0];
                alu_upd = 1'b1;
            end
            default: ; // reserved (and MUL when MUL_EN=0): all zero
        endcase
        // CMP reports the subtraction's zero/sign, not those of the passed-through a
        alu_z = (op_q == OP_CMP) ? (diff[MSB:0] == '0) : (alu_res == '0);
        alu_n = (op_q == OP_CMP) ? diff[MSB] : alu_res[MSB];
    end

    // Request capture, result/flag registers and stored carry/borrow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            cst       <= 1'b0;
            bst       <= 1'b0;
        end else begin
            if (state == ST_IDLE && accept) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= opcode_t'(opcode);
            end
            if (state == ST_EXEC) begin
                result    <= alu_res;
                result_hi <= '0;
                carry     <= alu_c;
                borrow    <= alu_b;
                zero      <= alu_z;
                overflow  <= alu_v;
                negative  <= alu_n;
                if (alu_upd) begin
                    cst <= alu_c;
                    bst <= alu_b;
                end
            end
            if (state == ST_MUL && mul_done) begin
                result    <= mul_prod[WIDTH-1:0];
                result_hi <= mul_prod[2*WIDTH-1:WIDTH];
                carry     <= 1'b0;
                borrow    <= 1'b0;
                zero      <= (mul_prod == '0);
                overflow  <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                negative  <= mul_prod[2*WIDTH-1];
            end
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, result_hi;
  logic         carry, borrow, zero, overflow, negative;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected response: {result_hi, result, carry, borrow, zero, overflow, negative}
  logic [2*W+4:0] exp_q[$];

  seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .borrow    (borrow),
    .zero      (zero),
    .overflow  (overflow),
    .negative  (negative),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W+4:0] outs();
    return {result_hi, result, carry, borrow, zero, overflow, negative};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compares each response as it is handed off
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected response", 64'(outs()), 64'h0 - 64'h1);
      end else begin
        chk("response", 64'(outs()), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver: issue one request, push its expected response, measure latency,
  // optionally stall the consumer and check outputs hold.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ehi, input logic [W-1:0] eres,
                        input logic [4:0] efl, input int lat, input int stall);
    int cyc;
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    opcode   = op;
    in_valid = 1'b1;
    if (stall > 0) out_ready = 1'b0;
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    exp_q.push_back({ehi, eres, efl});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(lat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({name, " stall hold"}, 64'({out_valid, outs()}), 64'({1'b1, ehi, eres, efl}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    opcode    = '0;

    // reset state
    #1;
    chk("reset outputs", 64'(outs()), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset state", 64'(dbg_state), 64'd0);

    //      name      op     a      b      hi     res    cbzvn     lat stall
    run_op("ADD",     4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b10100, 1, 0);
    run_op("SUB",     4'd1,  8'h80, 8'h01, 8'h00, 8'h7F, 5'b10010, 1, 0);
    run_op("SBB",     4'd9,  8'h00, 8'h00, 8'h00, 8'h00, 5'b10100, 1, 0);
    run_op("ADD Cst", 4'd0,  8'hF0, 8'h20, 8'h00, 8'h10, 5'b10000, 1, 0);
    run_op("ADC",     4'd8,  8'h01, 8'h01, 8'h00, 8'h03, 5'b00000, 1, 0);
    run_op("MUL",     4'd13, 8'h10, 8'h20, 8'h02, 8'h00, 5'b00010, 9, 3);

    // reset during a multiply: no response, outputs cleared at once
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; opcode = 4'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mul abort outputs", 64'({out_valid, in_ready, outs()}), 64'd0);
    chk("mul abort state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort release in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort no out_valid", 64'(seen), 64'd0);

    run_op("ROR",     4'd11, 8'h01, 8'h00, 8'h00, 8'h80, 5'b10001, 1, 0);
    run_op("ASR",     4'd12, 8'h80, 8'h00, 8'h00, 8'hC0, 5'b00001, 1, 0);
    run_op("AND",     4'd2,  8'hF0, 8'h3C, 8'h00, 8'h30, 5'b00000, 1, 0);
    run_op("OR",      4'd3,  8'h0F, 8'hF0, 8'h00, 8'hFF, 5'b00001, 1, 0);
    run_op("XOR",     4'd4,  8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00100, 1, 0);
    run_op("SHL",     4'd5,  8'h81, 8'h00, 8'h00, 8'h02, 5'b10000, 1, 0);
    run_op("SHR",     4'd6,  8'h01, 8'h00, 8'h00, 8'h00, 5'b10100, 1, 0);
    run_op("PASS",    4'd7,  8'h5A, 8'h33, 8'h00, 8'h5A, 5'b00000, 1, 0);
    run_op("CMP",     4'd14, 8'h90, 8'h10, 8'h00, 8'h90, 5'b10001, 1, 0);
    run_op("RSV",     4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 5'b00100, 1, 0);
    run_op("MUL max", 4'd13, 8'hFF, 8'hFF, 8'hFE, 8'h01, 5'b00011, 9, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal: 4..64).
REQ-002 SHALL have parameter MUL_EN, default 1; 0 removes the multiplier and makes MUL a reserved opcode.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a, b  input  WIDTH  operands, sampled on accept.
REQ-008 SHALL have port opcode  input  4  operation select, sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result and flags are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  primary result; low half for MUL.
REQ-012 SHALL have port result_hi  output  WIDTH  high half for MUL, 0 otherwise.
REQ-013 SHALL have port carry, borrow, zero, overflow, negative  output  1 each  status flags.

Function
REQ-014 SHALL decode opcodes as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS(a), 8 ADC, 9 SBB, 10 ROL, 11 ROR, 12 ASR, 13 MUL (unsigned), 14 CMP, 15 reserved (result 0, flags 0 except zero=1).
REQ-015 SHALL accept a request when in_valid && in_ready; in_ready = 1 only in state IDLE and only while rst is low.
REQ-016 SHALL implement FSM IDLE -> EXEC (non-MUL, 1 cycle) or MUL (WIDTH cycles) -> DONE -> IDLE on out_ready; a reserved opcode follows the EXEC path.
REQ-017 SHALL assert out_valid exactly in DONE: 1 cycle after accept for non-MUL ops, WIDTH+1 cycles after accept for MUL.
REQ-018 SHALL hold result, result_hi and all flags stable while out_valid=1 and out_ready=0.
REQ-019 SHALL form ADD/ADC as a+b(+Cst), setting carry from the WIDTH+1 sum bit; SUB/SBB/CMP as a-b(-Bst), setting borrow=1 when unsigned a < b(+Bst) and carry=~borrow.
REQ-020 SHALL set overflow for add ops to (a[MSB]==b[MSB]) && (out[MSB]!=a[MSB]), for sub ops to (a[MSB]!=b[MSB]) && (out[MSB]!=a[MSB]), and to 0 for logic, shift and PASS ops.
REQ-021 SHALL, for SHL/ROL, set carry=a[MSB]; for SHR/ROR/ASR, set carry=a[0]; ASR replicates a[MSB]; rotates are by one bit.
REQ-022 SHALL, for CMP, output result=a with flags as for SUB.
REQ-023 SHALL, for MUL, produce {result_hi,result}=a*b by radix-2 shift-add over WIDTH cycles, with carry=0, borrow=0, overflow=(result_hi!=0), zero=(a*b==0) and negative=result_hi[MSB].
REQ-024 SHALL, for non-MUL ops, set zero=(result==0) and negative=result[MSB].
REQ-025 SHALL keep stored flags Cst/Bst, updated from carry/borrow on every completed ADD, SUB, ADC, SBB, CMP, shift or rotate, and unchanged by logic, PASS, MUL and reserved ops.
REQ-026 SHALL ignore in_valid outside IDLE; operands are not re-sampled.

Reset
REQ-027 SHALL, on rst, immediately force state IDLE, out_valid=0, in_ready=0, result=0, result_hi=0, all flags 0 and Cst=Bst=0.
REQ-028 SHALL abort any in-flight EXEC or MUL on rst without producing out_valid; in_ready=1 in the first cycle after rst falls.

Structure
REQ-029 SHALL take the opcode enum, the FSM state enum and the opcode width constant from shared package alu_pkg.
REQ-030 SHALL place the sequential multiplier in sub-module alu_mul_seq (WIDTH parameter, start/done, registered operands), instantiated only when MUL_EN=1.

Verification (WIDTH=8)
REQ-031 SHALL check ADD a=0xFF, b=0x01 -> result 0x00, carry=1, zero=1, overflow=0, with out_valid one cycle after accept.
REQ-032 SHALL check SUB a=0x80, b=0x01 -> result 0x7F, overflow=1, borrow=0, carry=1; then SBB a=0x00, b=0x00 -> result 0x00, borrow=0.
REQ-033 SHALL check ADD a=0xF0, b=0x20 (Cst=1), then ADC a=0x01, b=0x01 -> result 0x03, carry=0.
REQ-034 SHALL check MUL a=0x10, b=0x20 -> result=0x00, result_hi=0x02, overflow=1, zero=0, out_valid at accept+9; with out_ready held low 3 cycles, outputs stay stable.
REQ-035 SHALL check rst asserted 4 cycles into MUL a=0xFF, b=0xFF -> all outputs 0 at once, out_valid never rises, in_ready=1 in the cycle after release.
REQ-036 SHALL check ROR a=0x01 -> result 0x80, carry=1; then ASR a=0x80 -> result 0xC0, carry=0, negative=1.
